// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibit / request-to-send, 11-bit frame serializer clocked by the device, ACK check.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES   = 10000,
  parameter int TIMEOUT_CYCLES   = 200000,
  parameter int DONE_WAIT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX_TD = (TIMEOUT_CYCLES > DONE_WAIT_CYCLES) ? TIMEOUT_CYCLES : DONE_WAIT_CYCLES;
  localparam int CNT_MAX    = (INHIBIT_CYCLES > CNT_MAX_TD) ? INHIBIT_CYCLES : CNT_MAX_TD;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  // A stalled device clock raises tx_error TIMEOUT_CYCLES cycles after the REQ cycle.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(DONE_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE, ERR
  } state_e;

  state_e           state_q;
  logic [9:0]       frame_q;
  logic [3:0]       bit_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clk_meta_q, clk_sync_q, clk_prev_q;
  logic             data_meta_q, data_sync_q;
  logic             fall;

  assign cnt_d = cnt_q + 1'b1;
  assign fall  = clk_prev_q & ~clk_sync_q;

  // Synchronizers idle high so reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      tx_ready    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            frame_q    <= {1'b1, ~^tx_data, tx_data};
            cnt_q      <= '0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state_q    <= INHIBIT;
          end
        end
        INHIBIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == INH_PRE) ps2_data_oe <= 1'b1;
          if (cnt_q == INH_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          cnt_q     <= '0;
          bit_cnt_q <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (fall) begin
            ps2_data_oe <= ~frame_q[0];
            frame_q     <= {1'b0, frame_q[9:1]};
            bit_cnt_q   <= bit_cnt_q + 1'b1;
            cnt_q       <= '0;
            if (bit_cnt_q == 4'd9) state_q <= ACK;
          end else if (cnt_q == TO_LAST) begin
            state_q     <= ERR;
            tx_error    <= 1'b1;
            ps2_data_oe <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ACK: begin
          if (fall) begin
            cnt_q <= '0;
            if (!data_sync_q) begin
              state_q <= WAIT_IDLE;
            end else begin
              state_q     <= ERR;
              tx_error    <= 1'b1;
              ps2_data_oe <= 1'b0;
            end
          end else if (cnt_q == TO_LAST) begin
            state_q     <= ERR;
            tx_error    <= 1'b1;
            ps2_data_oe <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_IDLE: begin
          if (clk_sync_q && data_sync_q) begin
            state_q <= DONE;
            tx_done <= 1'b1;
          end else if (cnt_q == DW_LAST) begin
            state_q     <= ERR;
            tx_error    <= 1'b1;
            ps2_data_oe <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE, ERR: begin
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
